uart_ins_loader: RTL and testbench

//  Serial instruction loader that drives the SingleClockMIPS instruction write port (WE/W_Ins).

---
 rtl/uart_ins_loader_pkg.sv | 13 +
 rtl/uart_ins_loader_rx.sv | 80 ++++++++
 rtl/uart_ins_loader.sv | 96 +++++++++
 tb/tb_uart_ins_loader.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/uart_ins_loader_pkg.sv
// uart_ins_loader_pkg: shared RX state encoding, baud divider helper and write-address width.
package uart_ins_loader_pkg;
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;
  localparam int ADDR_W = 8;
  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction
endpackage

// File: rtl/uart_ins_loader_rx.sv
// uart_rx: 8N1 receiver; ports CLK/RST(async low)/RXD in, rx_data/rx_valid/rx_ferr/rx_busy out.
module uart_rx
  import uart_ins_loader_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RXD,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ferr,
  output logic       rx_busy
);
  localparam int CW = $clog2(DIV);
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d, ferr_q, ferr_d;
  logic          s1_q, s2_q, prev_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q & ~s2_q) state_d = RX_START;
      end
      RX_START: if (cnt_q == CW'(DIV / 2 - 1)) begin
        cnt_d   = '0;
        bit_d   = '0;
        state_d = s2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt_q == CW'(DIV - 1)) begin
        cnt_d  = '0;
        data_d = {s2_q, data_q[7:1]};
        bit_d  = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = RX_STOP;
      end
      RX_STOP: if (cnt_q == CW'(DIV - 1)) begin
        cnt_d   = '0;
        state_d = RX_IDLE;
        valid_d = s2_q;
        ferr_d  = ~s2_q;
      end
    endcase
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      s1_q    <= RXD;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
    end
  end
  assign rx_data  = data_q;
  assign rx_valid = valid_q;
  assign rx_ferr  = ferr_q;
  assign rx_busy  = state_q != RX_IDLE;
endmodule

// File: rtl/uart_ins_loader.sv
// uart_ins_loader: UART byte stream to 32-bit instruction writes; CLK/RST(async low)/RXD/CLR in, WE/W_Ins/W_Addr/LDR_CNT/FULL/FERR/BUSY out.
module uart_ins_loader
  import uart_ins_loader_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter int MAX_WORDS   = 256
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RXD,
  input  logic              CLR,
  output logic              WE,
  output logic [31:0]       W_Ins,
  output logic [ADDR_W-1:0] W_Addr,
  output logic [8:0]        LDR_CNT,
  output logic              FULL,
  output logic              FERR,
  output logic              BUSY
);
  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int TW  = $clog2(TIMEOUT_CYC);
  logic [7:0]        rx_data;
  logic              rx_valid, rx_ferr, rx_busy;
  logic [1:0]        idx_q, idx_d;
  logic [23:0]       shadow_q, shadow_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [8:0]        cnt_q, cnt_d;
  logic              ferr_q, ferr_d, we_q, we_d;
  logic [31:0]       ins_q, ins_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              full;
  uart_rx #(.DIV(DIV)) u_rx (
    .CLK(CLK), .RST(RST), .RXD(RXD),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ferr(rx_ferr), .rx_busy(rx_busy)
  );
  assign full = cnt_q == 9'(MAX_WORDS);
  always_comb begin
    idx_d    = idx_q;
    shadow_d = shadow_q;
    tmr_d    = (idx_q == 2'd0) ? '0 : tmr_q + 1'b1;
    cnt_d    = cnt_q;
    ferr_d   = ferr_q | rx_ferr;
    we_d     = 1'b0;
    ins_d    = ins_q;
    addr_d   = addr_q;
    if (CLR) begin
      idx_d  = '0;
      tmr_d  = '0;
      cnt_d  = '0;
      ferr_d = 1'b0;
    end else if (rx_valid) begin
      tmr_d = '0;
      idx_d = idx_q + 2'd1;
      if (idx_q != 2'd3) shadow_d[{idx_q, 3'b000} +: 8] = rx_data;
      else if (!full) begin
        we_d   = 1'b1;
        ins_d  = {rx_data, shadow_q};
        addr_d = cnt_q[ADDR_W-1:0];
        cnt_d  = cnt_q + 1'b1;
      end
    end else if (idx_q != 2'd0 && tmr_q == TW'(TIMEOUT_CYC - 1)) begin
      idx_d = '0;
      tmr_d = '0;
    end
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      idx_q    <= '0;
      shadow_q <= '0;
      tmr_q    <= '0;
      cnt_q    <= '0;
      ferr_q   <= 1'b0;
      we_q     <= 1'b0;
      ins_q    <= '0;
      addr_q   <= '0;
    end else begin
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      tmr_q    <= tmr_d;
      cnt_q    <= cnt_d;
      ferr_q   <= ferr_d;
      we_q     <= we_d;
      ins_q    <= ins_d;
      addr_q   <= addr_d;
    end
  end
  assign WE      = we_q;
  assign W_Ins   = ins_q;
  assign W_Addr  = addr_q;
  assign LDR_CNT = cnt_q;
  assign FULL    = full;
  assign FERR    = ferr_q;
  assign BUSY    = rx_busy | (idx_q != 2'd0);
endmodule

// File: tb/tb_uart_ins_loader.sv
// tb_uart_ins_loader: randomized scoreboard bench for uart_ins_loader.
module tb_uart_ins_loader;
  localparam int DIV  = 10;
  localparam int TMO  = 200;
  localparam int MAXW = 4;
  logic        CLK = 1'b0, RST = 1'b0, RXD = 1'b1, CLR = 1'b0;
  logic        WE, FULL, FERR, BUSY;
  logic [31:0] W_Ins;
  logic [7:0]  W_Addr;
  logic [8:0]  LDR_CNT;
  always #5 CLK = ~CLK;
  uart_ins_loader #(
    .CLK_HZ(1_000_000), .BAUD(100_000), .TIMEOUT_CYC(TMO), .MAX_WORDS(MAXW)
  ) dut (
    .CLK(CLK), .RST(RST), .RXD(RXD), .CLR(CLR), .WE(WE), .W_Ins(W_Ins),
    .W_Addr(W_Addr), .LDR_CNT(LDR_CNT), .FULL(FULL), .FERR(FERR), .BUSY(BUSY)
  );
  typedef struct {
    logic [7:0]  a;
    logic [31:0] w;
  } exp_t;
  exp_t        exp_q[$];
  int          checks = 0, failures = 0;
  logic [31:0] m_part;
  int          m_nb, m_cnt;
  logic        m_ferr;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic void m_discard();
    m_part = '0;
    m_nb   = 0;
  endfunction
  function automatic void m_clear();
    m_discard();
    m_cnt  = 0;
    m_ferr = 1'b0;
  endfunction
  function automatic void m_byte(input logic [7:0] b);
    exp_t e;
    m_part[8*m_nb +: 8] = b;
    m_nb++;
    if (m_nb == 4) begin
      if (m_cnt < MAXW) begin
        e.a = 8'(m_cnt);
        e.w = m_part;
        exp_q.push_back(e);
        m_cnt++;
      end
      m_discard();
    end
  endfunction
  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    if (stop) m_byte(b);
    else m_ferr = 1'b1;
    @(negedge CLK) RXD = 1'b0;
    repeat (DIV) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      repeat (DIV) @(negedge CLK);
    end
    RXD = stop;
    repeat (DIV) @(negedge CLK);
    RXD = 1'b1;
    repeat (2) @(negedge CLK);
  endtask
  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask
  task automatic drain(input string nm);
    repeat (30) @(negedge CLK);
    chk(nm, exp_q.size(), 0);
    exp_q.delete();
  endtask
  task automatic do_clr();
    @(negedge CLK) CLR = 1'b1;
    @(negedge CLK) CLR = 1'b0;
    m_clear();
  endtask
  always @(negedge CLK) begin
    if (WE) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_we: W_Ins=%h W_Addr=%0d with no word pending", W_Ins, W_Addr);
      end else begin
        e = exp_q.pop_front();
        chk("w_ins", W_Ins, e.w);
        chk("w_addr", 32'(W_Addr), 32'(e.a));
        chk("ldr_cnt_at_we", 32'(LDR_CNT), 32'(e.a) + 1);
      end
    end
  end
  initial begin
    m_clear();
    repeat (3) @(negedge CLK);
    chk("rst_we", 32'(WE), 0);
    chk("rst_w_ins", W_Ins, 0);
    chk("rst_w_addr", 32'(W_Addr), 0);
    chk("rst_ldr_cnt", 32'(LDR_CNT), 0);
    chk("rst_full", 32'(FULL), 0);
    chk("rst_ferr", 32'(FERR), 0);
    chk("rst_busy", 32'(BUSY), 0);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    send_byte(8'h08); send_byte(8'h00); send_byte(8'h11); send_byte(8'h20);
    drain("t1_pending");
    chk("t1_ldr_cnt", 32'(LDR_CNT), 1);
    chk("t1_last_word", W_Ins, 32'h20110008);
    do_clr();
    for (int n = 0; n < 5; n++) send_word($urandom);
    drain("t2_pending");
    chk("t2_full", 32'(FULL), 1);
    chk("t2_ldr_cnt", 32'(LDR_CNT), MAXW);
    do_clr();
    chk("clr_full", 32'(FULL), 0);
    chk("clr_ldr_cnt", 32'(LDR_CNT), 0);
    send_byte(8'h55, 1'b0);
    repeat (5) @(negedge CLK);
    chk("t3_ferr", 32'(FERR), 1);
    chk("t3_busy", 32'(BUSY), 0);
    send_word($urandom);
    drain("t3_pending");
    chk("t3_ferr_sticky", 32'(FERR), 1);
    chk("t3_ldr_cnt", 32'(LDR_CNT), 1);
    do_clr();
    chk("t3_ferr_clr", 32'(FERR), 0);
    send_byte(8'($urandom)); send_byte(8'($urandom));
    repeat (250) @(negedge CLK);
    m_discard();
    chk("t4_busy_after_timeout", 32'(BUSY), 0);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    drain("t4_pending");
    chk("t4_word", W_Ins, 32'hDDCCBBAA);
    chk("t4_ldr_cnt", 32'(LDR_CNT), 1);
    @(negedge CLK) RXD = 1'b0;
    repeat (3) @(negedge CLK);
    RXD = 1'b1;
    repeat (DIV / 2 + 3) @(negedge CLK);
    chk("t5_busy", 32'(BUSY), 0);
    chk("t5_ferr", 32'(FERR), 0);
    drain("t5_pending");
    chk("t5_ldr_cnt", 32'(LDR_CNT), 1);
    send_byte(8'($urandom));
    @(negedge CLK) RXD = 1'b0;
    repeat (DIV * 3) @(negedge CLK);
    RST = 1'b0;
    RXD = 1'b1;
    m_clear();
    exp_q.delete();
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (5) @(negedge CLK);
    chk("t6_ldr_cnt_rst", 32'(LDR_CNT), 0);
    chk("t6_busy_rst", 32'(BUSY), 0);
    send_word($urandom);
    drain("t6_pending");
    chk("t6_ldr_cnt", 32'(LDR_CNT), 1);
    do_clr();
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        send_byte(8'($urandom), 1'b0);
        repeat (TMO + 60) @(negedge CLK);
        m_discard();
      end else begin
        send_byte(8'($urandom));
        if ($urandom_range(0, 9) == 0) begin
          repeat (TMO + 60) @(negedge CLK);
          m_discard();
        end else repeat ($urandom_range(0, 20)) @(negedge CLK);
      end
      if (m_cnt == MAXW && m_nb == 0 && $urandom_range(0, 1) == 1) begin
        drain("rnd_pending_pre_clr");
        do_clr();
      end
    end
    drain("rnd_pending");
    chk("rnd_ldr_cnt", 32'(LDR_CNT), 32'(m_cnt));
    chk("rnd_full", 32'(FULL), 32'(m_cnt == MAXW));
    chk("rnd_ferr", 32'(FERR), 32'(m_ferr));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
